// File: rtl/load_data_ext_if.sv
`default_nettype none
// ============================================================================
// Module      : load_data_ext_if
// Description : Request, memory-read and response signals of the load data
//               extension block. The slave modport is the block's view and
//               the master modport is the view of whatever drives it.
// Revision    : 1.0 - initial release
// ============================================================================
interface load_data_ext_if;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_type;
  logic [31:0] req_addr;
  logic        mem_rd_en;
  logic [31:0] mem_rd_addr;
  logic        mem_rdata_valid;
  logic [31:0] mem_rdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_misalign;
  logic        rsp_timeout;

  modport slave (
    input  req_valid, req_type, req_addr, mem_rdata_valid, mem_rdata, rsp_ready,
    output req_ready, mem_rd_en, mem_rd_addr, rsp_valid, rsp_data,
           rsp_misalign, rsp_timeout
  );

  modport master (
    output req_valid, req_type, req_addr, mem_rdata_valid, mem_rdata, rsp_ready,
    input  req_ready, mem_rd_en, mem_rd_addr, rsp_valid, rsp_data,
           rsp_misalign, rsp_timeout
  );
endinterface
`default_nettype wire

// File: rtl/load_data_ext.sv
`default_nettype none
// ============================================================================
// Module      : load_data_ext
// Description : M-stage load unit. Accepts one load, issues a word-aligned
//               read, waits a bounded time for the data, then extracts and
//               sign/zero-extends the byte, half or word and holds it under a
//               valid/ready handshake. Flags misaligned loads and timeouts.
// Revision    : 1.0 - initial release
// ============================================================================
module load_data_ext #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  wire logic         clk,
  input  wire logic         reset_n,
  load_data_ext_if.slave    bus
);

  localparam logic [2:0] c_lb  = 3'd1;
  localparam logic [2:0] c_lbu = 3'd2;
  localparam logic [2:0] c_lh  = 3'd3;
  localparam logic [2:0] c_lhu = 3'd4;
  localparam logic [2:0] c_lw  = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        w_rd_en;
  logic [2:0]  r_type;
  logic [1:0]  r_off;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0] r_data;
  logic        r_misalign;
  logic        r_timeout;

  logic        w_type_ok;
  logic        w_misalign;
  logic        w_accept;
  logic        w_timeout_hit;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_ext;

  assign w_type_ok = (bus.req_type >= c_lb) && (bus.req_type <= c_lw);
  assign w_misalign = (((bus.req_type == c_lh) || (bus.req_type == c_lhu)) && bus.req_addr[0])
                    || ((bus.req_type == c_lw) && (bus.req_addr[1:0] != 2'b00));
  assign w_accept      = (r_state == S_IDLE) && bus.req_valid && w_type_ok;
  assign w_timeout_hit = (r_cnt == CNT_W'(TIMEOUT - 1));

  // State register; reset abandons any load in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next-state and read strobe; the strobe fires only in the accept cycle.
  always_comb begin
    w_next  = r_state;
    w_rd_en = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_misalign) begin
            w_next = S_DONE;
          end else begin
            w_rd_en = 1'b1;
            w_next  = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (bus.mem_rdata_valid || w_timeout_hit) w_next = S_DONE;
      end
      S_DONE: begin
        if (bus.rsp_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Select the addressed byte/half and extend it according to the load type.
  always_comb begin
    w_byte = 8'h00;
    case (r_off)
      2'd0:    w_byte = bus.mem_rdata[7:0];
      2'd1:    w_byte = bus.mem_rdata[15:8];
      2'd2:    w_byte = bus.mem_rdata[23:16];
      default: w_byte = bus.mem_rdata[31:24];
    endcase
    w_half = r_off[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    w_ext  = 32'h0;
    case (r_type)
      c_lb:    w_ext = {{24{w_byte[7]}}, w_byte};
      c_lbu:   w_ext = {24'h0, w_byte};
      c_lh:    w_ext = {{16{w_half[15]}}, w_half};
      c_lhu:   w_ext = {16'h0, w_half};
      c_lw:    w_ext = bus.mem_rdata;
      default: w_ext = 32'h0;
    endcase
  end

  // Request latch, wait counter and result registers. Results only change on
  // accept or while waiting, so they stay stable throughout DONE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_type     <= 3'd0;
      r_off      <= 2'd0;
      r_cnt      <= '0;
      r_data     <= 32'h0;
      r_misalign <= 1'b0;
      r_timeout  <= 1'b0;
    end else if (w_accept) begin
      r_type     <= bus.req_type;
      r_off      <= bus.req_addr[1:0];
      r_cnt      <= '0;
      r_data     <= 32'h0;
      r_misalign <= w_misalign;
      r_timeout  <= 1'b0;
    end else if (r_state == S_WAIT) begin
      if (bus.mem_rdata_valid) begin
        r_data <= w_ext;
      end else if (w_timeout_hit) begin
        r_timeout <= 1'b1;
        r_data    <= 32'h0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign bus.req_ready    = (r_state == S_IDLE);
  assign bus.mem_rd_en    = w_rd_en;
  assign bus.mem_rd_addr  = {bus.req_addr[31:2], 2'b00};
  assign bus.rsp_valid    = (r_state == S_DONE);
  assign bus.rsp_data     = r_data;
  assign bus.rsp_misalign = r_misalign;
  assign bus.rsp_timeout  = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_load_data_ext.sv
`default_nettype none
// ============================================================================
// Module      : tb_load_data_ext
// Description : Self-checking bench for load_data_ext: a table of load
//               vectors plus directed sequences for timeout, back-pressure
//               and reset-during-wait.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_load_data_ext;

  localparam int TIMEOUT = 16;

  logic clk;
  logic reset_n;
  int   n_vec;
  int   n_err;

  load_data_ext_if bus ();

  load_data_ext #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  typ;
    logic [31:0] addr;
    logic [31:0] rdata;
    logic [31:0] exp;
    logic        mis;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete load: accept, data one cycle later (if aligned), handshake.
  task automatic run_vec(input vec_t v);
    logic [31:0] exp_addr;
    exp_addr = {v.addr[31:2], 2'b00};
    bus.req_valid = 1'b1;
    bus.req_type  = v.typ;
    bus.req_addr  = v.addr;
    bus.mem_rdata_valid = 1'b1;       // must be ignored in the accept cycle
    bus.mem_rdata = 32'hA5A5A5A5;
    #1;
    chk("accept_req_ready", bus.req_ready, 32'd1);
    chk("accept_mem_rd_en", bus.mem_rd_en, {31'd0, !v.mis});
    chk("accept_mem_rd_addr", bus.mem_rd_addr, exp_addr);
    tick();
    bus.req_valid = 1'b0;
    bus.req_type  = 3'd0;
    bus.mem_rdata_valid = 1'b0;
    if (!v.mis) begin
      chk("wait_rsp_valid", bus.rsp_valid, 32'd0);
      bus.mem_rdata_valid = 1'b1;
      bus.mem_rdata = v.rdata;
      tick();
      bus.mem_rdata_valid = 1'b0;
      bus.mem_rdata = 32'h0;
    end
    chk("done_rsp_valid", bus.rsp_valid, 32'd1);
    chk("done_rsp_data", bus.rsp_data, v.exp);
    chk("done_rsp_misalign", bus.rsp_misalign, {31'd0, v.mis});
    chk("done_rsp_timeout", bus.rsp_timeout, 32'd0);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    chk("after_rsp_valid", bus.rsp_valid, 32'd0);
    chk("after_req_ready", bus.req_ready, 32'd1);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    vecs[0]  = '{3'd1, 32'h0000_1003, 32'h8012_3456, 32'hFFFF_FF80, 1'b0}; // lb
    vecs[1]  = '{3'd2, 32'h0000_1003, 32'h8012_3456, 32'h0000_0080, 1'b0}; // lbu
    vecs[2]  = '{3'd3, 32'h0000_2002, 32'hBEEF_1234, 32'hFFFF_BEEF, 1'b0}; // lh
    vecs[3]  = '{3'd4, 32'h0000_2000, 32'hBEEF_1234, 32'h0000_1234, 1'b0}; // lhu
    vecs[4]  = '{3'd5, 32'h0000_0006, 32'h0000_0000, 32'h0000_0000, 1'b1}; // lw mis
    vecs[5]  = '{3'd1, 32'h0000_0000, 32'h0000_007F, 32'h0000_007F, 1'b0};
    vecs[6]  = '{3'd1, 32'h0000_0001, 32'h0000_A500, 32'hFFFF_FFA5, 1'b0};
    vecs[7]  = '{3'd2, 32'h0000_0002, 32'h00C3_0000, 32'h0000_00C3, 1'b0};
    vecs[8]  = '{3'd5, 32'h0000_0100, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0};
    vecs[9]  = '{3'd3, 32'h0000_0001, 32'h1111_1111, 32'h0000_0000, 1'b1}; // lh mis
    vecs[10] = '{3'd4, 32'h0000_0003, 32'h1111_1111, 32'h0000_0000, 1'b1}; // lhu mis
    vecs[11] = '{3'd5, 32'h0000_0002, 32'h1111_1111, 32'h0000_0000, 1'b1}; // lw mis
    vecs[12] = '{3'd4, 32'h0000_0002, 32'h8001_FFFF, 32'h0000_8001, 1'b0};
    vecs[13] = '{3'd3, 32'h0000_0000, 32'h0000_7FFF, 32'h0000_7FFF, 1'b0};
    vecs[14] = '{3'd5, 32'h0000_0001, 32'h2222_2222, 32'h0000_0000, 1'b1}; // lw mis

    bus.req_valid = 1'b0;
    bus.req_type  = 3'd0;
    bus.req_addr  = 32'h0;
    bus.mem_rdata_valid = 1'b0;
    bus.mem_rdata = 32'h0;
    bus.rsp_ready = 1'b0;
    reset_n = 1'b0;
    tick();
    tick();
    chk("rst_req_ready", bus.req_ready, 32'd1);
    chk("rst_rsp_valid", bus.rsp_valid, 32'd0);
    chk("rst_mem_rd_en", bus.mem_rd_en, 32'd0);
    chk("rst_rsp_data", bus.rsp_data, 32'd0);
    chk("rst_rsp_misalign", bus.rsp_misalign, 32'd0);
    chk("rst_rsp_timeout", bus.rsp_timeout, 32'd0);
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < 15; i++) run_vec(vecs[i]);

    // Timeout: no data for TIMEOUT wait cycles.
    bus.req_valid = 1'b1; bus.req_type = 3'd5; bus.req_addr = 32'h10;
    #1;
    chk("to_mem_rd_en", bus.mem_rd_en, 32'd1);
    tick();
    bus.req_valid = 1'b0; bus.req_type = 3'd0;
    for (int i = 0; i < TIMEOUT - 1; i++) tick();
    chk("to_not_yet_valid", bus.rsp_valid, 32'd0);
    tick();
    chk("to_rsp_valid", bus.rsp_valid, 32'd1);
    chk("to_rsp_timeout", bus.rsp_timeout, 32'd1);
    chk("to_rsp_data", bus.rsp_data, 32'd0);
    bus.rsp_ready = 1'b1; tick(); bus.rsp_ready = 1'b0;

    // Data on the last wait cycle wins over the timeout.
    bus.req_valid = 1'b1; bus.req_type = 3'd5; bus.req_addr = 32'h10;
    tick();
    bus.req_valid = 1'b0; bus.req_type = 3'd0;
    chk("last_timeout_cleared", bus.rsp_timeout, 32'd0);
    for (int i = 0; i < TIMEOUT - 1; i++) tick();
    bus.mem_rdata_valid = 1'b1; bus.mem_rdata = 32'h1234_5678;
    tick();
    bus.mem_rdata_valid = 1'b0;
    chk("last_rsp_valid", bus.rsp_valid, 32'd1);
    chk("last_rsp_data", bus.rsp_data, 32'h1234_5678);
    chk("last_rsp_timeout", bus.rsp_timeout, 32'd0);

    // Back-pressure: hold DONE for 3 cycles with a pending request.
    bus.req_valid = 1'b1; bus.req_type = 3'd5; bus.req_addr = 32'h20;
    bus.mem_rdata_valid = 1'b1; bus.mem_rdata = 32'hCAFE_F00D;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_rsp_valid", bus.rsp_valid, 32'd1);
      chk("bp_rsp_data", bus.rsp_data, 32'h1234_5678);
      chk("bp_req_ready", bus.req_ready, 32'd0);
      chk("bp_mem_rd_en", bus.mem_rd_en, 32'd0);
      tick();
    end
    bus.mem_rdata_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    chk("bp_idle_req_ready", bus.req_ready, 32'd1);
    chk("bp_accept_rd_en", bus.mem_rd_en, 32'd1);
    chk("bp_accept_rd_addr", bus.mem_rd_addr, 32'h20);
    tick();
    bus.req_valid = 1'b0; bus.req_type = 3'd0;
    bus.mem_rdata_valid = 1'b1; bus.mem_rdata = 32'h0BAD_CAFE;
    tick();
    bus.mem_rdata_valid = 1'b0;
    chk("bp_next_data", bus.rsp_data, 32'h0BAD_CAFE);
    chk("bp_next_valid", bus.rsp_valid, 32'd1);
    bus.rsp_ready = 1'b1; tick(); bus.rsp_ready = 1'b0;

    // Reset while waiting; late data must be ignored.
    bus.req_valid = 1'b1; bus.req_type = 3'd5; bus.req_addr = 32'h40;
    tick();
    bus.req_valid = 1'b0; bus.req_type = 3'd0;
    chk("rw_in_wait", bus.req_ready, 32'd0);
    reset_n = 1'b0;
    #1;
    chk("rw_req_ready", bus.req_ready, 32'd1);
    chk("rw_rsp_valid", bus.rsp_valid, 32'd0);
    tick();
    reset_n = 1'b1;
    bus.mem_rdata_valid = 1'b1; bus.mem_rdata = 32'hFFFF_FFFF;
    tick();
    tick();
    bus.mem_rdata_valid = 1'b0;
    chk("rw_late_rsp_valid", bus.rsp_valid, 32'd0);
    chk("rw_late_req_ready", bus.req_ready, 32'd1);
    chk("rw_late_data", bus.rsp_data, 32'd0);

    // Non-load types are never accepted.
    for (int t = 0; t < 8; t++) begin
      logic [2:0] ty;
      ty = 3'(t);
      if (ty == 3'd0 || ty == 3'd6 || ty == 3'd7) begin
        bus.req_valid = 1'b1; bus.req_type = ty; bus.req_addr = 32'h0;
        #1;
        chk("nl_mem_rd_en", bus.mem_rd_en, 32'd0);
        tick();
        chk("nl_req_ready", bus.req_ready, 32'd1);
        chk("nl_rsp_valid", bus.rsp_valid, 32'd0);
      end
    end
    bus.req_valid = 1'b0; bus.req_type = 3'd0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
